exc_ctrl: RTL and testbench

Pipeline exception/trap sequencer in front of the CP0 register block.
- Detects taken syscall/break/teq/eret and mtc0 events from the EX stage.
- Stalls and flushes younger stages, then issues a single registered `cp0_ena` commit pulse carrying the CP0 control fields.
- Finally drives a one-cycle PC redirect to the exception vector or to EPC.

---
 rtl/exc_pkg.sv | 31 +++
 rtl/exc_prio_enc.sv | 52 +++++
 rtl/exc_ctrl.sv | 172 +++++++++++++++++
 tb/tb_exc_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception/trap sequencer.
package exc_pkg;

  localparam logic [31:0] EXC_VEC_DEFAULT = 32'h0040_0004;

  localparam logic [4:0] CAUSE_NONE    = 5'b00000;
  localparam logic [4:0] CAUSE_SYSCALL = 5'b01000;
  localparam logic [4:0] CAUSE_BREAK   = 5'b01001;
  localparam logic [4:0] CAUSE_TEQ     = 5'b01101;

  // STATUS bit positions that gate the traps
  localparam int ST_IE  = 0;
  localparam int ST_SYS = 1;
  localparam int ST_BRK = 2;
  localparam int ST_TEQ = 3;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DRAIN    = 2'd1,
    S_COMMIT   = 2'd2,
    S_REDIRECT = 2'd3
  } state_t;

  // What the commit pulse represents
  typedef enum logic [1:0] {
    KIND_EXC  = 2'd0,
    KIND_ERET = 2'd1,
    KIND_MTC0 = 2'd2
  } kind_t;

endpackage

// File: rtl/exc_prio_enc.sv
// Masks the EX-stage event flags with STATUS and picks the highest-priority
// taken event: syscall > break > teq > eret > mtc0.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic        ex_valid,
  input  logic        ex_syscall,
  input  logic        ex_break,
  input  logic        ex_teq,
  input  logic        ex_teq_hit,
  input  logic        ex_eret,
  input  logic        ex_mtc0,
  input  logic [3:0]  status,
  output logic        take,
  output kind_t       kind,
  output logic [4:0]  cause
);

  logic sys_taken;
  logic brk_taken;
  logic teq_taken;

  assign sys_taken = ex_syscall & status[ST_IE] & status[ST_SYS];
  assign brk_taken = ex_break & status[ST_IE] & status[ST_BRK];
  assign teq_taken = ex_teq & ex_teq_hit & status[ST_IE] & status[ST_TEQ];

  // Masked traps fall through to lower-priority events, or to no action
  always_comb begin
    take  = 1'b0;
    kind  = KIND_EXC;
    cause = CAUSE_NONE;
    if (ex_valid) begin
      if (sys_taken) begin
        take  = 1'b1;
        cause = CAUSE_SYSCALL;
      end else if (brk_taken) begin
        take  = 1'b1;
        cause = CAUSE_BREAK;
      end else if (teq_taken) begin
        take  = 1'b1;
        cause = CAUSE_TEQ;
      end else if (ex_eret) begin
        take = 1'b1;
        kind = KIND_ERET;
      end else if (ex_mtc0) begin
        take = 1'b1;
        kind = KIND_MTC0;
      end
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/trap sequencer: drains the pipe, issues one CP0 commit pulse and
// then a one-cycle PC redirect. All outputs are registered from next state.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a taken event from EX
// DRAIN    | stall + flush; wait for minimum drain time and mem idle
// COMMIT   | single-cycle cp0_ena strobe with qualifier/cause/pc
// REDIRECT | single-cycle PC load to EXC_VEC or EPC
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VEC      = EXC_VEC_DEFAULT,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_syscall,
  input  logic        ex_break,
  input  logic        ex_teq,
  input  logic        ex_teq_hit,
  input  logic        ex_eret,
  input  logic        ex_mtc0,
  input  logic [31:0] ex_pc,
  input  logic        mem_busy,
  input  logic [31:0] cp0_status,
  input  logic [31:0] cp0_epc,
  output logic        cp0_ena,
  output logic        cp0_exception,
  output logic        cp0_eret,
  output logic        cp0_mtc0,
  output logic [4:0]  cp0_cause,
  output logic [31:0] cp0_pc,
  output logic        stall_ex,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES);

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt, cnt_dec;
  kind_t       kind_q, kind_nxt;
  logic [4:0]  cause_q, cause_nxt;
  logic [31:0] pc_q, pc_nxt;

  logic        take;
  kind_t       enc_kind;
  logic [4:0]  enc_cause;

  logic        ena_nxt, exc_nxt, eret_nxt, mtc0_nxt;
  logic [4:0]  cause_o_nxt;
  logic [31:0] pc_o_nxt;
  logic        stall_nxt, flush_nxt, rv_nxt, busy_nxt;
  logic [31:0] rpc_nxt;

  // Only the low STATUS bits gate traps; the rest are deliberately ignored
  logic        unused_status;
  assign unused_status = ^cp0_status[31:4];

  exc_prio_enc u_prio (
    .ex_valid   (ex_valid),
    .ex_syscall (ex_syscall),
    .ex_break   (ex_break),
    .ex_teq     (ex_teq),
    .ex_teq_hit (ex_teq_hit),
    .ex_eret    (ex_eret),
    .ex_mtc0    (ex_mtc0),
    .status     (cp0_status[3:0]),
    .take       (take),
    .kind       (enc_kind),
    .cause      (enc_cause)
  );

  // Saturating decrement; DRAIN exits once the count reaches zero
  assign cnt_dec = (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;

  // Next-state, latched event fields and next registered outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    kind_nxt  = kind_q;
    cause_nxt = cause_q;
    pc_nxt    = pc_q;
    case (state)
      S_IDLE: begin
        if (take) begin
          kind_nxt  = enc_kind;
          cause_nxt = enc_cause;
          pc_nxt    = ex_pc;
          if (enc_kind == KIND_MTC0) begin
            state_nxt = S_COMMIT;
          end else begin
            cnt_nxt   = CNT_LOAD;
            state_nxt = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        cnt_nxt = cnt_dec;
        if (cnt_dec == 4'd0 && !mem_busy) state_nxt = S_COMMIT;
      end
      S_COMMIT:   state_nxt = (kind_q == KIND_MTC0) ? S_IDLE : S_REDIRECT;
      S_REDIRECT: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase

    ena_nxt     = (state_nxt == S_COMMIT);
    exc_nxt     = ena_nxt && (kind_nxt == KIND_EXC);
    eret_nxt    = ena_nxt && (kind_nxt == KIND_ERET);
    mtc0_nxt    = ena_nxt && (kind_nxt == KIND_MTC0);
    cause_o_nxt = ena_nxt ? cause_nxt : CAUSE_NONE;
    pc_o_nxt    = ena_nxt ? pc_nxt : 32'h0;
    busy_nxt    = (state_nxt != S_IDLE);
    stall_nxt   = busy_nxt;
    flush_nxt   = (state_nxt == S_DRAIN) ||
                  ((state_nxt == S_COMMIT) && (kind_nxt != KIND_MTC0));
    rv_nxt      = (state_nxt == S_REDIRECT);
    rpc_nxt     = 32'h0;
    if (rv_nxt) rpc_nxt = (kind_nxt == KIND_ERET) ? cp0_epc : EXC_VEC;
  end

  // State register and latched event fields
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      kind_q  <= KIND_EXC;
      cause_q <= CAUSE_NONE;
      pc_q    <= 32'h0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      kind_q  <= kind_nxt;
      cause_q <= cause_nxt;
      pc_q    <= pc_nxt;
    end
  end

  // Output registers, reflecting the state entered at this edge
  always_ff @(posedge clk) begin
    if (!rst) begin
      cp0_ena        <= 1'b0;
      cp0_exception  <= 1'b0;
      cp0_eret       <= 1'b0;
      cp0_mtc0       <= 1'b0;
      cp0_cause      <= CAUSE_NONE;
      cp0_pc         <= 32'h0;
      stall_ex       <= 1'b0;
      flush          <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
      busy           <= 1'b0;
    end else begin
      cp0_ena        <= ena_nxt;
      cp0_exception  <= exc_nxt;
      cp0_eret       <= eret_nxt;
      cp0_mtc0       <= mtc0_nxt;
      cp0_cause      <= cause_o_nxt;
      cp0_pc         <= pc_o_nxt;
      stall_ex       <= stall_nxt;
      flush          <= flush_nxt;
      redirect_valid <= rv_nxt;
      redirect_pc    <= rpc_nxt;
      busy           <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed cases plus randomized events
// compared against a timeline model of each transaction.
module tb_exc_ctrl;

  localparam logic [31:0] VEC   = 32'h0040_0004;
  localparam int          FLUSH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_syscall, ex_break, ex_teq, ex_teq_hit, ex_eret, ex_mtc0;
  logic [31:0] ex_pc, cp0_status, cp0_epc;
  logic        mem_busy;
  logic        cp0_ena, cp0_exception, cp0_eret, cp0_mtc0;
  logic [4:0]  cp0_cause;
  logic [31:0] cp0_pc, redirect_pc;
  logic        stall_ex, flush, redirect_valid, busy;

  int checks = 0;
  int errors = 0;

  exc_ctrl #(.EXC_VEC(VEC), .FLUSH_CYCLES(FLUSH)) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_syscall     (ex_syscall),
    .ex_break       (ex_break),
    .ex_teq         (ex_teq),
    .ex_teq_hit     (ex_teq_hit),
    .ex_eret        (ex_eret),
    .ex_mtc0        (ex_mtc0),
    .ex_pc          (ex_pc),
    .mem_busy       (mem_busy),
    .cp0_status     (cp0_status),
    .cp0_epc        (cp0_epc),
    .cp0_ena        (cp0_ena),
    .cp0_exception  (cp0_exception),
    .cp0_eret       (cp0_eret),
    .cp0_mtc0       (cp0_mtc0),
    .cp0_cause      (cp0_cause),
    .cp0_pc         (cp0_pc),
    .stall_ex       (stall_ex),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {busy, stall, flush, ena, exception, eret, mtc0, redirect_valid}
  function automatic logic [7:0] ctrl_obs();
    return {busy, stall_ex, flush, cp0_ena, cp0_exception, cp0_eret, cp0_mtc0, redirect_valid};
  endfunction

  // Reference decision: 0 none, 1 exception, 2 eret, 3 mtc0; first taken event in
  // priority order wins.
  function automatic int model_kind(input logic v, sc, br, tq, hit, er, mt,
                                    input logic [31:0] st, output logic [4:0] cause);
    bit taken [5];
    int kinds [5]   = '{1, 1, 1, 2, 3};
    logic [4:0] cz [5] = '{5'd8, 5'd9, 5'd13, 5'd0, 5'd0};
    cause = 5'd0;
    if (!v) return 0;
    taken[0] = sc && st[0] && st[1];
    taken[1] = br && st[0] && st[2];
    taken[2] = tq && hit && st[0] && st[3];
    taken[3] = er;
    taken[4] = mt;
    for (int i = 0; i < 5; i++)
      if (taken[i]) begin
        cause = cz[i];
        return kinds[i];
      end
    return 0;
  endfunction

  task automatic drive_idle();
    ex_valid = 0; ex_syscall = 0; ex_break = 0; ex_teq = 0; ex_teq_hit = 0;
    ex_eret = 0; ex_mtc0 = 0; mem_busy = 0;
  endtask

  task automatic drive_garbage();
    ex_valid   = 1'($urandom);
    ex_syscall = 1'($urandom);
    ex_break   = 1'($urandom);
    ex_teq     = 1'($urandom);
    ex_teq_hit = 1'($urandom);
    ex_eret    = 1'($urandom);
    ex_mtc0    = 1'($urandom);
    ex_pc      = $urandom;
    cp0_status = $urandom;
  endtask

  // One event presented for a single cycle, mem_busy high for nb cycles starting
  // with the event cycle. Called at a negedge; returns at a negedge in IDLE.
  task automatic run_txn(input string name, input logic v, sc, br, tq, hit, er, mt,
                         input logic [31:0] st, input logic [31:0] pc,
                         input logic [31:0] epc, input int nb, input bit garbage);
    logic [4:0] cause;
    int kind, c, last;
    logic [7:0] exp;
    kind = model_kind(v, sc, br, tq, hit, er, mt, st, cause);
    ex_valid = v; ex_syscall = sc; ex_break = br; ex_teq = tq; ex_teq_hit = hit;
    ex_eret = er; ex_mtc0 = mt; ex_pc = pc; cp0_status = st; cp0_epc = epc;
    mem_busy = (nb > 0);
    c = (nb > FLUSH) ? nb : FLUSH;
    if (kind == 3) c = 0;
    last = (kind == 0) ? 2 : (kind == 3) ? 1 : c + 2;
    for (int k = 0; k <= last; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = 8'h00;
      if (kind == 3) begin
        if (k == 0) exp = 8'b1101_0010;
      end else if (kind != 0) begin
        if (k < c)           exp = 8'b1110_0000;
        else if (k == c)     exp = (kind == 1) ? 8'b1111_1000 : 8'b1111_0100;
        else if (k == c + 1) exp = 8'b1100_0001;
      end
      chk($sformatf("%s ctrl k=%0d", name, k), {24'h0, ctrl_obs()}, {24'h0, exp});
      if (kind != 0 && k == c) begin
        chk($sformatf("%s cause", name), {27'h0, cp0_cause}, {27'h0, cause});
        if (kind != 3) chk($sformatf("%s cp0_pc", name), cp0_pc, pc);
      end
      if (kind != 0 && kind != 3 && k == c + 1)
        chk($sformatf("%s redirect_pc", name), redirect_pc, (kind == 2) ? epc : VEC);
      if (garbage && kind != 0 && k < last) drive_garbage();
      else drive_idle();
      mem_busy = (k + 1 < nb);
      if (k == last) drive_idle();
    end
  endtask

  initial begin
    rst = 0;
    drive_idle();
    ex_pc = 0; cp0_status = 0; cp0_epc = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset ctrl", {24'h0, ctrl_obs()}, 32'h0);
    chk("reset redirect_pc", redirect_pc, 32'h0);
    rst = 1;

    run_txn("syscall", 1, 1, 0, 0, 0, 0, 0, 32'h1f, 32'h0040_0100, 32'h0, 0, 0);
    run_txn("break_masked", 1, 0, 1, 0, 0, 0, 0, 32'h1b, 32'h0040_0200, 32'h0, 0, 0);
    run_txn("eret", 1, 0, 0, 0, 0, 1, 0, 32'h0, 32'h0040_0300, 32'h0040_0100, 0, 0);
    run_txn("mtc0_vs_sys", 1, 1, 0, 0, 0, 0, 1, 32'h1f, 32'h0040_0400, 32'h0, 0, 0);
    run_txn("mtc0", 1, 0, 0, 0, 0, 0, 1, 32'h0, 32'h0040_0500, 32'h0, 0, 0);
    run_txn("teq_busy", 1, 0, 0, 1, 1, 0, 0, 32'h1f, 32'h0040_0600, 32'h0, 5, 0);
    run_txn("teq_nohit", 1, 0, 0, 1, 0, 0, 0, 32'h1f, 32'h0040_0700, 32'h0, 0, 0);

    // reset in the middle of a drain drops the pending commit and redirect
    ex_valid = 1; ex_syscall = 1; cp0_status = 32'h1f; ex_pc = 32'h0040_0800;
    @(posedge clk);
    @(negedge clk);
    drive_idle();
    chk("pre-rst busy", {31'h0, busy}, 32'h1);
    rst = 0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst ctrl", {24'h0, ctrl_obs()}, 32'h0);
    chk("midrst cause", {27'h0, cp0_cause}, 32'h0);
    chk("midrst cp0_pc", cp0_pc, 32'h0);
    chk("midrst redirect_pc", redirect_pc, 32'h0);
    rst = 1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("postrst ctrl k=%0d", k), {24'h0, ctrl_obs()}, 32'h0);
    end

    for (int n = 0; n < 150; n++) begin
      run_txn($sformatf("rnd%0d", n), 1'($urandom_range(0, 7) != 0),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
              1'($urandom_range(0, 2) == 0), 1'($urandom),
              1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
              $urandom, $urandom, $urandom, $urandom_range(0, 6), 1'b1);
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        @(negedge clk);
        chk("idle gap ctrl", {24'h0, ctrl_obs()}, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
